seq_nonrestoring_divider: RTL and testbench
===========================================

Name: seq_nonrestoring_divider

Overview:
Parametrised, handshaked successor to the team's fixed 128-bit sequential non-restoring divider. Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock. Adds start/busy/done handshake, divide-by-zero detection and optional signed mode. Sits beside the datapath as a multi-cycle arithmetic unit; debug state/count outputs are retained for bench visibility.

Parameters:
WIDTH, 32, operand/result width in bits (>=4).
CW, $clog2(WIDTH)+1, width of iteration counter and count_out (derived, do not override).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
signed_op  input  1  signed division request; ignored unless NRDIV_SIGNED_EN.
dividend  input  WIDTH  sampled with start.
divisor  input  WIDTH  sampled with start.
quotient  output  WIDTH  result, held until next accepted start.
remainder  output  WIDTH  result, held until next accepted start.
busy  output  1  high from cycle after accept until done cycle, inclusive.
done  output  1  one-cycle pulse; results valid.
div_by_zero  output  1  sticky with results; set when divisor==0.
state_out  output  3  current FSM state encoding.
count_out  output  CW  remaining iterations.

Behaviour:
- Reset (async assert): state IDLE; quotient, remainder, count_out = 0; busy, done, div_by_zero = 0. Mid-operation reset aborts; no done.
- States: IDLE=0, ITER=1, FIX=2, DONE=3; other codes unreachable, recover to IDLE.
- IDLE: start=1 at edge -> latch operands; A (WIDTH+1 bits) = 0, Q = dividend (magnitude if signed), M = divisor (magnitude), count = WIDTH; go ITER. If divisor==0 -> go DONE directly, quotient = all ones, remainder = dividend, div_by_zero = 1.
- ITER, per cycle: shift {A,Q} left 1; if A was non-negative A = A - M else A = A + M; Q[0] = ~A_new[WIDTH]; count--. After WIDTH cycles (count reaches 0) -> FIX.
- FIX (one cycle): if A negative, A = A + M. Apply sign correction (signed mode only). Load quotient/remainder -> DONE.
- DONE (one cycle): done=1, busy=1 -> IDLE.
- Latency: start-accept cycle = cycle 0; ITER cycles 1..WIDTH; FIX WIDTH+1; done in cycle WIDTH+2 (34 at WIDTH=32). Divide-by-zero: done in cycle 1.
- start outside IDLE ignored (no queuing). start high in the DONE cycle ignored; accepted from the following IDLE cycle.
- div_by_zero cleared on next accepted start.
- All arithmetic unsigned modulo 2^WIDTH; internal accumulator WIDTH+1 bits.

Optional Feature:
NRDIV_SIGNED_EN defined: when signed_op=1 at accept, operands are two's complement. Quotient truncates toward zero; remainder takes dividend's sign. Overflow (most-negative / -1) gives quotient = most-negative, remainder 0. Divide-by-zero result unchanged (all ones, dividend).
Undefined: signed_op ignored, all operations unsigned; no negation logic synthesised.

Decomposition:
- Package nrdiv_pkg: state enum typedef and encodings (IDLE/ITER/FIX/DONE), state width constant 3.
- Sub-module nrdiv_step: combinational single-iteration shift/add-sub of {A,Q} with M. Parameterised by WIDTH; instantiated once.

Test Plan:
1. WIDTH=32, dividend 4294967295 / divisor 25, start pulse -> done in cycle 34, quotient 171798691, remainder 20, busy high cycles 1..34.
2. Sweep dividend 0..255 x divisor {1,3,7,15,31,63,127,255} -> every result matches the / and % operators; done exactly once per op.
3. dividend 100, divisor 0 -> done in cycle 1, quotient 0xFFFFFFFF, remainder 100, div_by_zero=1; next op 10/3 -> div_by_zero=0, q=3, r=1.
4. start re-asserted during ITER with different operands -> ignored; results are those of the first op, single done.
5. reset asserted in cycle 10 of 1000/7 -> all outputs 0 immediately, state_out=0, no done. A fresh 1000/7 afterwards -> q=142, r=6.
6. signed_op=1, dividend 0xFFFFFFF9 (-7) / 2 -> with NRDIV_SIGNED_EN: q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Without it: q=2147483644, r=1. With it, 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0.

Source files
------------

// File: rtl/nrdiv_pkg.sv
// Shared state encodings for the sequential non-restoring divider.
package nrdiv_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] nrdiv_state_t;

    localparam nrdiv_state_t S_IDLE = 3'd0;
    localparam nrdiv_state_t S_ITER = 3'd1;
    localparam nrdiv_state_t S_FIX  = 3'd2;
    localparam nrdiv_state_t S_DONE = 3'd3;

endpackage

// File: rtl/nrdiv_step.sv
// One non-restoring iteration: shift {A,Q} left, then add or subtract M according to
// the old sign of A; the new quotient bit is the inverse of the new sign. Combinational.
module nrdiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] a_shift;

    assign a_shift = {a[WIDTH-1:0], q[WIDTH-1]};
    assign a_next  = a[WIDTH] ? (a_shift + {1'b0, m}) : (a_shift - {1'b0, m});
    assign q_next  = {q[WIDTH-2:0], ~a_next[WIDTH]};

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Sequential non-restoring divider, one quotient bit per clock, done at cycle WIDTH+2 after accept.
// Define NRDIV_SIGNED_EN to honour signed_op (two's complement, truncating toward zero).
module seq_nonrestoring_divider
    import nrdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [STATE_W-1:0] state_out,
    output logic [CW-1:0]      count_out
);

    nrdiv_state_t     state;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] mr;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   acc_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    nrdiv_step #(.WIDTH(WIDTH)) u_step (
        .a      (acc),
        .q      (qr),
        .m      (mr),
        .a_next (acc_step),
        .q_next (q_step)
    );

    // Final remainder is below M, so the restore can be done at WIDTH bits.
    assign rem_fix = acc[WIDTH] ? (acc[WIDTH-1:0] + mr) : acc[WIDTH-1:0];

`ifdef NRDIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    assign dvd_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dvs_mag = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign q_res   = neg_q ? -qr : qr;
    assign r_res   = neg_r ? -rem_fix : rem_fix;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == S_IDLE && start) begin
            neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= signed_op && dividend[WIDTH-1];
        end
    end
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign dvd_mag          = dividend;
    assign dvs_mag          = divisor;
    assign q_res            = qr;
    assign r_res            = rem_fix;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            acc         <= '0;
            qr          <= '0;
            mr          <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc         <= '0;
                        qr          <= dvd_mag;
                        mr          <= dvs_mag;
                        div_by_zero <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= dividend;
                            count     <= '0;
                            state     <= S_DONE;
                        end else begin
                            count <= CW'(WIDTH);
                            state <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    acc   <= acc_step;
                    qr    <= q_step;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient  <= q_res;
                    remainder <= r_res;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_out = state;
    assign count_out = count;

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Scoreboard bench for seq_nonrestoring_divider at WIDTH=32.
module tb_seq_nonrestoring_divider;

    localparam int W  = 32;
    localparam int CW = $clog2(W) + 1;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          signed_op;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [2:0]    state_out;
    logic [CW-1:0] count_out;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    seq_nonrestoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .state_out   (state_out),
        .count_out   (count_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=done required=no_done q=0x%0h r=0x%0h",
                             quotient, remainder);
                end else begin
                    e = exp_q.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", div_by_zero, e.dbz);
                end
            end
        end
    end

    task automatic launch(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn);
        @(negedge clk);
        dividend  = dvd;
        divisor   = dvs;
        signed_op = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts cycles after accept until done; busy must hold through the done cycle.
    task automatic wait_done(input int exp_lat);
        int lat;
        int busy_low;
        lat      = 0;
        busy_low = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy !== 1'b1) busy_low++;
        end while (done !== 1'b1 && lat < 100);
        chk("latency", lat, exp_lat);
        chk("busy_low_cycles", busy_low, 0);
        @(negedge clk);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                          input int exp_lat);
        exp_t e;
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        exp_q.push_back(e);
        launch(dvd, dvs, sgn);
        wait_done(exp_lat);
    endtask

    initial begin
        logic [W-1:0] dvs_tab [8];
        exp_t e;
        dvs_tab = '{32'd1, 32'd3, 32'd7, 32'd15, 32'd31, 32'd63, 32'd127, 32'd255};

        reset     = 1'b1;
        start     = 1'b0;
        signed_op = 1'b0;
        dividend  = '0;
        divisor   = '0;
        @(negedge clk);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_state", state_out, 0);
        chk("rst_count", count_out, 0);
        @(negedge clk);
        reset = 1'b0;

        // Full-range dividend
        run_op(32'hFFFF_FFFF, 32'd25, 1'b0, 32'd171798691, 32'd20, 1'b0, 34);

        // Divide by zero, then a normal op clears the flag
        run_op(32'd100, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd100, 1'b1, 1);
        chk("dbz_sticky", div_by_zero, 1'b1);
        run_op(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0, 34);

        // Start during ITER is ignored
        e.q = 32'd55; e.r = 32'd5; e.dbz = 1'b0;
        exp_q.push_back(e);
        launch(32'd500, 32'd9, 1'b0);
        repeat (4) @(negedge clk);
        dividend = 32'd77;
        divisor  = 32'd5;
        start    = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(34 - 7);

        // Reset in cycle 10 aborts the operation
        launch(32'd1000, 32'd7, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_state", state_out, 0);
        chk("abort_count", count_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0, 34);

        // Signed requests
`ifdef NRDIV_SIGNED_EN
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34);
`else
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'd2147483644, 32'd1, 1'b0, 34);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 34);
`endif
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1);

        // Sweep small dividends against a divisor table
        foreach (dvs_tab[i]) begin
            for (int n = 0; n < 256; n++) begin
                run_op(n, dvs_tab[i], 1'b0, n / dvs_tab[i], n % dvs_tab[i], 1'b0, 34);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
